accumulator_sequencer: RTL and testbench

Fetch/decode/execute controller for the 16-bit accumulator machine. It sequences PC, MAR, MBR, IR and AC against the byte-addressed, little-endian main memory, which has one synchronous read port.
It implements the opcodes Add, Halt, Load, Store, Clear, Skip and Jump, one instruction at a time, using a multi-cycle FSM.
It replaces the stub controller as the top-level sequencer of the CPU datapath.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/accumulator_sequencer.sv | 151 +++++++++++++++
 tb/tb_accumulator_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator machine: opcodes, skip
// conditions, controller state encoding and the instruction-word stride.
package cpu_pkg;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_HALT  = 4'd1;
   localparam logic [3:0] OP_LOAD  = 4'd2;
   localparam logic [3:0] OP_STORE = 4'd3;
   localparam logic [3:0] OP_CLEAR = 4'd4;
   localparam logic [3:0] OP_SKIP  = 4'd5;
   localparam logic [3:0] OP_JUMP  = 4'd6;

   localparam logic [1:0] SKIP_NEG   = 2'd0;
   localparam logic [1:0] SKIP_ZERO  = 2'd1;
   localparam logic [1:0] SKIP_POS   = 2'd2;
   localparam logic [1:0] SKIP_NEVER = 2'd3;

   localparam logic [15:0] PC_STEP = 16'd2;

   typedef enum logic [2:0] {
      ST_FETCH    = 3'd0,
      ST_LOAD_IR  = 3'd1,
      ST_DECODE   = 3'd2,
      ST_MEM_RD   = 3'd3,
      ST_MEM_DATA = 3'd4,
      ST_MEM_WR   = 3'd5,
      ST_HALTED   = 3'd6
   } state_t;

   // Skip decision on the accumulator; "positive" means strictly greater than zero.
   function automatic logic skip_taken(input logic [1:0] cond, input logic [15:0] value);
      logic taken;
      taken = 1'b0;
      case (cond)
         SKIP_NEG:  taken = value[15];
         SKIP_ZERO: taken = (value == 16'h0000);
         SKIP_POS:  taken = !value[15] && (value != 16'h0000);
         default:   taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/accumulator_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator machine,
// driving PC/MAR/MBR/IR/AC against a single synchronous-read memory port.
module accumulator_sequencer #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] PC_STEP  = cpu_pkg::PC_STEP
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic [15:0] mem_rdata,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_we,
   output logic [15:0] pc,
   output logic [15:0] acc,
   output logic [15:0] ir,
   output logic [15:0] mar,
   output logic [15:0] mbr,
   output logic        halted,
   output logic        illegal,
   output logic        instr_done
);
   import cpu_pkg::*;

   state_t      state_q;
   logic [15:0] pc_q;
   logic [15:0] acc_q;
   logic [15:0] ir_q;
   logic [15:0] mar_q;
   logic [15:0] mbr_q;
   logic        halted_q;
   logic        illegal_q;
   logic        instr_done_q;

   logic [3:0]  opcode;
   logic [15:0] operand_addr;
   logic [15:0] add_sum;

   assign opcode       = ir_q[15:12];
   assign operand_addr = {4'h0, ir_q[11:0]};
   assign add_sum      = acc_q + mem_rdata;

   // Address and write strobe follow the state register directly so that an
   // asynchronous reset kills a Store write within the same cycle.
   assign mem_addr  = (state_q == ST_FETCH) ? pc_q : mar_q;
   assign mem_we    = (state_q == ST_MEM_WR);
   assign mem_wdata = mbr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_FETCH;
         pc_q         <= RESET_PC;
         acc_q        <= 16'h0000;
         ir_q         <= 16'h0000;
         mar_q        <= 16'h0000;
         mbr_q        <= 16'h0000;
         halted_q     <= 1'b0;
         illegal_q    <= 1'b0;
         instr_done_q <= 1'b0;
      end else begin
         instr_done_q <= 1'b0;
         case (state_q)
            ST_FETCH: begin
               if (run) begin
                  mar_q   <= pc_q;
                  state_q <= ST_LOAD_IR;
               end
            end
            ST_LOAD_IR: begin
               ir_q    <= mem_rdata;
               mbr_q   <= mem_rdata;
               pc_q    <= pc_q + PC_STEP;
               state_q <= ST_DECODE;
            end
            ST_DECODE: begin
               case (opcode)
                  OP_ADD, OP_LOAD: begin
                     mar_q   <= operand_addr;
                     state_q <= ST_MEM_RD;
                  end
                  OP_STORE: begin
                     mar_q   <= operand_addr;
                     mbr_q   <= acc_q;
                     state_q <= ST_MEM_WR;
                  end
                  OP_CLEAR: begin
                     acc_q        <= 16'h0000;
                     instr_done_q <= 1'b1;
                     state_q      <= ST_FETCH;
                  end
                  OP_SKIP: begin
                     if (skip_taken(ir_q[11:10], acc_q)) begin
                        pc_q <= pc_q + PC_STEP;
                     end
                     instr_done_q <= 1'b1;
                     state_q      <= ST_FETCH;
                  end
                  OP_JUMP: begin
                     pc_q         <= operand_addr;
                     instr_done_q <= 1'b1;
                     state_q      <= ST_FETCH;
                  end
                  OP_HALT: begin
                     halted_q <= 1'b1;
                     state_q  <= ST_HALTED;
                  end
                  default: begin
                     illegal_q <= 1'b1;
                     halted_q  <= 1'b1;
                     state_q   <= ST_HALTED;
                  end
               endcase
            end
            ST_MEM_RD: begin
               state_q <= ST_MEM_DATA;
            end
            ST_MEM_DATA: begin
               mbr_q <= mem_rdata;
               // Only Add and Load ever reach this state.
               if (opcode == OP_LOAD) begin
                  acc_q <= mem_rdata;
               end else begin
                  acc_q <= add_sum;
               end
               instr_done_q <= 1'b1;
               state_q      <= ST_FETCH;
            end
            ST_MEM_WR: begin
               instr_done_q <= 1'b1;
               state_q      <= ST_FETCH;
            end
            ST_HALTED: begin
               state_q <= ST_HALTED;
            end
            default: begin
               state_q <= ST_FETCH;
            end
         endcase
      end
   end

   assign pc         = pc_q;
   assign acc        = acc_q;
   assign ir         = ir_q;
   assign mar        = mar_q;
   assign mbr        = mbr_q;
   assign halted     = halted_q;
   assign illegal    = illegal_q;
   assign instr_done = instr_done_q;

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Bench for accumulator_sequencer: byte-addressed memory model, directed
// programs and random straight-line programs checked against an ISA-level model.
module tb_accumulator_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic [15:0] mem_rdata;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic [15:0] pc, acc, ir, mar, mbr;
   logic        halted, illegal, instr_done;

   int checks = 0;
   int passes = 0;

   logic [7:0] mem     [0:65535];
   logic [7:0] ref_mem [0:65535];
   logic [15:0] addr_hi;

   always #5 clk = ~clk;

   accumulator_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
      .mem_rdata (mem_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .pc        (pc),
      .acc       (acc),
      .ir        (ir),
      .mar       (mar),
      .mbr       (mbr),
      .halted    (halted),
      .illegal   (illegal),
      .instr_done(instr_done)
   );

   // Little-endian memory with one synchronous read port and byte-pair writes.
   assign addr_hi = mem_addr + 16'd1;
   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata[7:0];
         mem[addr_hi]  <= mem_wdata[15:8];
      end
      mem_rdata <= {mem[addr_hi], mem[mem_addr]};
   end

   task automatic clear_mem();
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
   endtask

   task automatic put16(input logic [15:0] a, input logic [15:0] d);
      logic [15:0] a1;
      a1 = a + 16'd1;
      mem[a]  = d[7:0];
      mem[a1] = d[15:8];
   endtask

   function automatic logic [15:0] get16(input logic [15:0] a);
      logic [15:0] a1;
      a1 = a + 16'd1;
      return {mem[a1], mem[a]};
   endfunction

   task automatic start_reset();
      reset = 1'b1;
      run   = 1'b0;
      #1;
   endtask

   task automatic release_reset(input logic run_val);
      @(posedge clk);
      #1;
      run   = run_val;
      reset = 1'b0;
   endtask

   task automatic run_until_halt(input int budget, output int cycles, output int dones, output int wes);
      cycles = 0;
      dones  = 0;
      wes    = 0;
      while (halted !== 1'b1 && cycles < budget) begin
         @(posedge clk);
         #1;
         cycles++;
         if (instr_done === 1'b1) dones++;
         if (mem_we === 1'b1) wes++;
      end
   endtask

   // ISA-level reference: executes ref_mem one instruction at a time and
   // charges the documented cycle cost per instruction class.
   task automatic ref_run(output logic [15:0] r_acc, output logic [15:0] r_pc, output int cyc,
                          output int dn, output logic ill, output logic [15:0] last_ir);
      logic [15:0] w, a, d;
      logic        stop, taken;
      r_acc = 16'h0; r_pc = 16'h0; cyc = 0; dn = 0; ill = 1'b0; stop = 1'b0; last_ir = 16'h0;
      for (int steps = 0; steps < 1000 && !stop; steps++) begin
         w = {ref_mem[r_pc + 16'd1], ref_mem[r_pc]};
         last_ir = w;
         r_pc = r_pc + 16'd2;
         a = {4'h0, w[11:0]};
         d = {ref_mem[a + 16'd1], ref_mem[a]};
         case (w[15:12])
            4'd0: begin r_acc = r_acc + d; cyc += 5; dn++; end
            4'd2: begin r_acc = d; cyc += 5; dn++; end
            4'd3: begin ref_mem[a] = r_acc[7:0]; ref_mem[a + 16'd1] = r_acc[15:8]; cyc += 4; dn++; end
            4'd4: begin r_acc = 16'h0; cyc += 3; dn++; end
            4'd5: begin
               case (w[11:10])
                  2'd0:    taken = $signed(r_acc) < 0;
                  2'd1:    taken = (r_acc == 16'h0);
                  2'd2:    taken = $signed(r_acc) > 0;
                  default: taken = 1'b0;
               endcase
               if (taken) r_pc = r_pc + 16'd2;
               cyc += 3; dn++;
            end
            4'd6: begin r_pc = a; cyc += 3; dn++; end
            4'd1: begin cyc += 3; stop = 1'b1; end
            default: begin cyc += 3; ill = 1'b1; stop = 1'b1; end
         endcase
      end
   endtask

   task automatic test_reset();
      start_reset();
      clear_mem();
      checks++; if (pc !== 16'h0000) $display("FAIL reset_pc: got %h want 0000", pc); else passes++;
      checks++; if ({acc, ir, mar, mbr} !== 64'h0) $display("FAIL reset_regs: got acc=%h ir=%h mar=%h mbr=%h want all 0000", acc, ir, mar, mbr); else passes++;
      checks++; if ({halted, illegal, instr_done, mem_we} !== 4'b0000) $display("FAIL reset_flags: got h=%b i=%b d=%b we=%b want 0000", halted, illegal, instr_done, mem_we); else passes++;
      checks++; if (mem_addr !== 16'h0000) $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); else passes++;
      $display("test_reset done");
   endtask

   task automatic test_basic();
      int cyc, dn, we;
      start_reset();
      clear_mem();
      put16(16'h0000, 16'h2100); put16(16'h0002, 16'h0102);
      put16(16'h0004, 16'h3104); put16(16'h0006, 16'h1000);
      put16(16'h0100, 16'h1234); put16(16'h0102, 16'h0011);
      release_reset(1'b1);
      run_until_halt(100, cyc, dn, we);
      checks++; if (halted !== 1'b1) $display("FAIL basic_halted: got %b want 1", halted); else passes++;
      checks++; if (cyc != 17) $display("FAIL basic_cycles: got %0d want 17", cyc); else passes++;
      checks++; if (acc !== 16'h1245) $display("FAIL basic_acc: got %h want 1245", acc); else passes++;
      checks++; if (pc !== 16'h0008) $display("FAIL basic_pc: got %h want 0008", pc); else passes++;
      checks++; if (dn != 3) $display("FAIL basic_done_pulses: got %0d want 3", dn); else passes++;
      checks++; if ({mem[16'h0105], mem[16'h0104]} !== 16'h1245) $display("FAIL basic_store: got %h want 1245", {mem[16'h0105], mem[16'h0104]}); else passes++;
      checks++; if (we != 1) $display("FAIL basic_we_cycles: got %0d want 1", we); else passes++;
      $display("test_basic: cycles=%0d acc=%h pc=%h", cyc, acc, pc);
   endtask

   task automatic test_skip_jump();
      int cyc, dn, we;
      start_reset();
      clear_mem();
      put16(16'h0000, 16'h4000); put16(16'h0002, 16'h5400);
      put16(16'h0004, 16'h1000); put16(16'h0006, 16'h6020);
      put16(16'h0020, 16'h1000);
      release_reset(1'b1);
      run_until_halt(100, cyc, dn, we);
      checks++; if (pc !== 16'h0022) $display("FAIL skipjump_pc: got %h want 0022", pc); else passes++;
      checks++; if (acc !== 16'h0000) $display("FAIL skipjump_acc: got %h want 0000", acc); else passes++;
      checks++; if (cyc != 12) $display("FAIL skipjump_cycles: got %0d want 12", cyc); else passes++;
      checks++; if (dn != 3) $display("FAIL skipjump_done_pulses: got %0d want 3", dn); else passes++;
      $display("test_skip_jump: cycles=%0d pc=%h", cyc, pc);
   endtask

   task automatic test_skip_sign();
      int cyc, dn, we;
      start_reset();
      clear_mem();
      put16(16'h0000, 16'h2100); put16(16'h0002, 16'h5000);
      put16(16'h0004, 16'h1000); put16(16'h0006, 16'h5800);
      put16(16'h0008, 16'h1000); put16(16'h000A, 16'h1000);
      put16(16'h0100, 16'h8000);
      release_reset(1'b1);
      run_until_halt(100, cyc, dn, we);
      checks++; if (pc !== 16'h000A) $display("FAIL skipsign_pc: got %h want 000a", pc); else passes++;
      checks++; if (acc !== 16'h8000) $display("FAIL skipsign_acc: got %h want 8000", acc); else passes++;
      checks++; if (cyc != 14) $display("FAIL skipsign_cycles: got %0d want 14", cyc); else passes++;
      $display("test_skip_sign: cycles=%0d pc=%h", cyc, pc);
   endtask

   task automatic test_illegal();
      int cyc, dn, we;
      start_reset();
      clear_mem();
      put16(16'h0000, 16'h7ABC);
      release_reset(1'b1);
      run_until_halt(100, cyc, dn, we);
      repeat (5) begin
         @(posedge clk);
         #1;
         if (instr_done === 1'b1) dn++;
         if (mem_we === 1'b1) we++;
      end
      checks++; if ({halted, illegal} !== 2'b11) $display("FAIL illegal_flags: got h=%b i=%b want 11", halted, illegal); else passes++;
      checks++; if (pc !== 16'h0002) $display("FAIL illegal_pc: got %h want 0002", pc); else passes++;
      checks++; if (cyc != 3) $display("FAIL illegal_cycles: got %0d want 3", cyc); else passes++;
      checks++; if (we != 0 || dn != 0) $display("FAIL illegal_quiet: got we=%0d done=%0d want 0 0", we, dn); else passes++;
      checks++; if (ir !== 16'h7ABC) $display("FAIL illegal_ir: got %h want 7abc", ir); else passes++;
      $display("test_illegal: pc=%h illegal=%b", pc, illegal);
   endtask

   task automatic test_run_hold();
      int bad, lat, cyc, dn, we;
      start_reset();
      clear_mem();
      put16(16'h0000, 16'h4000); put16(16'h0002, 16'h1000);
      release_reset(1'b0);
      bad = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (pc !== 16'h0000 || mem_we !== 1'b0 || mem_addr !== 16'h0000 || instr_done !== 1'b0 || ir !== 16'h0000) bad++;
      end
      checks++; if (bad != 0) $display("FAIL runhold_idle: got %0d bad cycles want 0", bad); else passes++;
      run = 1'b1;
      lat = 0;
      while (instr_done !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++; if (lat != 3) $display("FAIL runhold_latency: got %0d want 3", lat); else passes++;
      run_until_halt(100, cyc, dn, we);
      checks++; if (pc !== 16'h0004 || halted !== 1'b1) $display("FAIL runhold_final: got pc=%h h=%b want 0004 1", pc, halted); else passes++;
      $display("test_run_hold: latency=%0d", lat);
   endtask

   task automatic test_reset_mid_store();
      int cyc, dn, we;
      start_reset();
      clear_mem();
      put16(16'h0000, 16'h2100); put16(16'h0002, 16'h3104); put16(16'h0004, 16'h1000);
      put16(16'h0100, 16'hBEEF); put16(16'h0104, 16'h55AA);
      release_reset(1'b1);
      repeat (8) @(posedge clk);
      #1;
      checks++; if (mem_we !== 1'b1 || mem_wdata !== 16'hBEEF || mar !== 16'h0104) $display("FAIL midstore_setup: got we=%b wd=%h mar=%h want 1 beef 0104", mem_we, mem_wdata, mar); else passes++;
      #2;
      reset = 1'b1;
      #1;
      checks++; if (mem_we !== 1'b0) $display("FAIL midstore_we_drop: got %b want 0", mem_we); else passes++;
      checks++; if ({pc, acc, ir, mar, mbr} !== 80'h0) $display("FAIL midstore_regs: got pc=%h acc=%h ir=%h mar=%h mbr=%h want all 0000", pc, acc, ir, mar, mbr); else passes++;
      @(posedge clk);
      #1;
      checks++; if (get16(16'h0104) !== 16'h55AA) $display("FAIL midstore_target: got %h want 55aa", get16(16'h0104)); else passes++;
      release_reset(1'b1);
      checks++; if (mem_addr !== 16'h0000) $display("FAIL midstore_restart_addr: got %h want 0000", mem_addr); else passes++;
      run_until_halt(100, cyc, dn, we);
      checks++; if (acc !== 16'hBEEF || pc !== 16'h0006 || cyc != 12) $display("FAIL midstore_rerun: got acc=%h pc=%h cyc=%0d want beef 0006 12", acc, pc, cyc); else passes++;
      checks++; if (get16(16'h0104) !== 16'hBEEF) $display("FAIL midstore_rerun_store: got %h want beef", get16(16'h0104)); else passes++;
      $display("test_reset_mid_store: rerun cycles=%0d", cyc);
   endtask

   task automatic test_pc_wrap();
      int cyc, dn, we;
      start_reset();
      clear_mem();
      put16(16'h0000, 16'h6FFE);
      for (int a = 16'h0FFE; a < 16'hFFFE; a += 4) put16(16'(a), 16'h5400);
      put16(16'hFFFE, 16'h1000);
      release_reset(1'b1);
      run_until_halt(50000, cyc, dn, we);
      checks++; if (halted !== 1'b1 || pc !== 16'h0000) $display("FAIL pcwrap_pc: got pc=%h h=%b want 0000 1", pc, halted); else passes++;
      checks++; if (cyc != 46086 || dn != 15361) $display("FAIL pcwrap_timing: got cyc=%0d done=%0d want 46086 15361", cyc, dn); else passes++;
      $display("test_pc_wrap: cycles=%0d", cyc);
   endtask

   task automatic test_random();
      int n, t, cyc, dn, we, r_cyc, r_dn;
      logic [15:0] w, r_acc, r_pc, r_ir, da;
      logic r_ill;
      for (int p = 0; p < 12; p++) begin
         start_reset();
         clear_mem();
         n = $urandom_range(4, 10);
         for (int i = 0; i < n; i++) begin
            da = 16'h0200 + 16'($urandom_range(0, 15) * 2);
            case ($urandom_range(0, 5))
               0: w = {4'h0, da[11:0]};
               1: w = {4'h2, da[11:0]};
               2: w = {4'h3, da[11:0]};
               3: w = 16'h4000;
               4: w = {4'h5, 2'($urandom_range(0, 3)), 10'($urandom)};
               default: begin
                  t = $urandom_range(i + 1, n);
                  w = {4'h6, 12'(t * 2)};
               end
            endcase
            put16(16'(i * 2), w);
         end
         if ($urandom_range(0, 3) == 0) put16(16'(n * 2), {4'($urandom_range(7, 15)), 12'($urandom)});
         else put16(16'(n * 2), 16'h1000);
         put16(16'(n * 2 + 2), 16'h1000);
         for (int j = 0; j < 16; j++) put16(16'h0200 + 16'(j * 2), 16'($urandom));
         for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
         ref_run(r_acc, r_pc, r_cyc, r_dn, r_ill, r_ir);
         release_reset(1'b1);
         run_until_halt(600, cyc, dn, we);
         checks++; if (halted !== 1'b1 || illegal !== r_ill) $display("FAIL rand%0d_flags: got h=%b i=%b want 1 %b", p, halted, illegal, r_ill); else passes++;
         checks++; if (acc !== r_acc || pc !== r_pc || ir !== r_ir) $display("FAIL rand%0d_regs: got acc=%h pc=%h ir=%h want %h %h %h", p, acc, pc, ir, r_acc, r_pc, r_ir); else passes++;
         checks++; if (cyc != r_cyc || dn != r_dn) $display("FAIL rand%0d_timing: got cyc=%0d done=%0d want %0d %0d", p, cyc, dn, r_cyc, r_dn); else passes++;
         for (int j = 0; j < 16; j++) begin
            da = 16'h0200 + 16'(j * 2);
            checks++;
            if (get16(da) !== {ref_mem[da + 16'd1], ref_mem[da]})
               $display("FAIL rand%0d_mem_%h: got %h want %h", p, da, get16(da), {ref_mem[da + 16'd1], ref_mem[da]});
            else passes++;
         end
         $display("random prog %0d: len=%0d cycles=%0d acc=%h pc=%h illegal=%b", p, n, cyc, acc, pc, illegal);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_skip_jump();
      test_skip_sign();
      test_illegal();
      test_run_hold();
      test_reset_mid_store();
      test_random();
      test_pc_wrap();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
